symm_decor4: RTL

Iterative symmetric-decorrelation update stage for the 4x4 FastICA unmixing matrix. It consumes the current matrix W and its Gram product P = W·Wᵀ, as produced by the symmetric multiplier stage. It computes W' = 1.5·W − 0.5·(P·W) in Q13 fixed point, one output element per cycle. The block sits directly downstream of the Gram multiplier in the decorrelation loop. Its result is fed back as the next W, and it reports the largest per-element change so the controller can judge convergence.

---
 rtl/symm_decor4.sv | 119 +++++++++++
 1 files changed

// File: rtl/symm_decor4.sv
// Symmetric-decorrelation update for the 4x4 FastICA unmixing matrix:
// W' = 1.5*W - 0.5*(P*W) in signed Q13, one element per cycle, with max |W'-W| report.
module symm_decor4 (
   input  logic               clk_dec4,
   input  logic               rstn_dec4,
   input  logic               start_dec4,
   input  logic signed [25:0] w11, w12, w13, w14, w21, w22, w23, w24,
   input  logic signed [25:0] w31, w32, w33, w34, w41, w42, w43, w44,
   input  logic signed [25:0] p11, p12, p13, p14, p21, p22, p23, p24,
   input  logic signed [25:0] p31, p32, p33, p34, p41, p42, p43, p44,
   output logic signed [25:0] o11, o12, o13, o14, o21, o22, o23, o24,
   output logic signed [25:0] o31, o32, o33, o34, o41, o42, o43, o44,
   output logic               busy_dec4,
   output logic               done_dec4,
   output logic        [25:0] max_delta_dec4
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [25:0] POS_MAX = 26'h1FF_FFFF;
   localparam logic [25:0] NEG_MIN = 26'h200_0000;

   state_t            state;
   logic [3:0]        idx;
   logic [25:0]       delta_acc;
   logic [15:0][25:0] w_in, p_in;
   logic [15:0][25:0] w_sh, p_sh;
   logic [15:0][25:0] o_r;

   // Element 0 sits in the low slice so that index == row*4 + col.
   assign w_in = {w44, w43, w42, w41, w34, w33, w32, w31,
                  w24, w23, w22, w21, w14, w13, w12, w11};
   assign p_in = {p44, p43, p42, p41, p34, p33, p32, p31,
                  p24, p23, p22, p21, p14, p13, p12, p11};
   assign {o44, o43, o42, o41, o34, o33, o32, o31,
           o24, o23, o22, o21, o14, o13, o12, o11} = o_r;

   // NOTE: the shadow bank is pure datapath storage, always written before it is
   // read, so it carries no reset and stays out of the async-reset control block.
   always_ff @(posedge clk_dec4) begin
      if (state == IDLE && start_dec4) begin
         w_sh <= w_in;
         p_sh <= p_in;
      end
   end

   logic signed [51:0] prod, acc;
   logic signed [25:0] q;
   logic signed [27:0] w28, q28, r, diff, adiff;
   logic        [25:0] o_new, d, delta_max;

   // NOTE: every combinational variable gets a default before any branch, and
   // blocking assignments are used here so the MAC sum chains within one cycle.
   always_comb begin
      prod = '0;
      acc  = '0;
      for (int k = 0; k < 4; k++) begin
         prod = 52'($signed(p_sh[{idx[3:2], 2'(k)}])) * 52'($signed(w_sh[{2'(k), idx[1:0]}]));
         acc  = acc + prod;
      end
      q   = acc[38:13];
      w28 = 28'($signed(w_sh[idx]));
      q28 = 28'(q);
      r   = w28 + (w28 >>> 1) - (q28 >>> 1);

      if (r > 28'sd33554431)
         o_new = POS_MAX;
      else if (r < -28'sd33554432)
         o_new = NEG_MIN;
      else
         o_new = r[25:0];

      diff  = 28'($signed(o_new)) - w28;
      adiff = diff[27] ? -diff : diff;
      d     = (adiff > 28'sd33554431) ? POS_MAX : adiff[25:0];
      delta_max = (d > delta_acc) ? d : delta_acc;
   end

   // NOTE: all control and output state uses non-blocking assignments.
   always_ff @(posedge clk_dec4 or negedge rstn_dec4) begin
      if (!rstn_dec4) begin
         state          <= IDLE;
         idx            <= '0;
         delta_acc      <= '0;
         o_r            <= '0;
         max_delta_dec4 <= '0;
         busy_dec4      <= 1'b0;
         done_dec4      <= 1'b0;
      end else begin
         done_dec4 <= 1'b0;
         case (state)
            IDLE: begin
               if (start_dec4) begin
                  idx       <= '0;
                  delta_acc <= '0;
                  busy_dec4 <= 1'b1;
                  state     <= CALC;
               end
            end
            CALC: begin
               o_r[idx]  <= o_new;
               delta_acc <= delta_max;
               idx       <= idx + 4'd1;
               if (idx == 4'd15) begin
                  max_delta_dec4 <= delta_max;
                  done_dec4      <= 1'b1;
                  state          <= DONE;
               end
            end
            DONE: begin
               busy_dec4 <= 1'b0;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
